bram_ring_buffer: RTL and testbench

BRAM_RING_BUFFER -- requirements
Module: bram_ring_buffer

---
 rtl/bram_ring_buffer.sv | 138 +++++++++++++
 tb/tb_bram_ring_buffer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bram_ring_buffer.sv
// FWFT ring buffer: one BRAM array, a prefetch register and an output register; write-to-rd_valid is 2 edges.
// No write backpressure (writes while full are dropped and counted); reads use valid/ready and sustain 1 word per cycle.
module bram_ring_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH:0]   fill_level,
  input  logic [ADDR_WIDTH:0]   threshold,
  output logic                  threshold_irq,
  output logic                  overflow,
  output logic [15:0]           drop_count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] FULL_LVL = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] mem_q;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   mem_cnt;
  logic [ADDR_WIDTH:0]   mem_cnt_nxt;
  logic [ADDR_WIDTH:0]   fill_nxt;
  logic                  q_vld;
  logic                  full;
  logic                  wr_acc;
  logic                  wr_take;
  logic                  rd_done;
  logic                  out_load;
  logic                  q_move;
  logic                  rd_issue;

  assign full     = (fill_level == FULL_LVL);
  assign wr_acc   = wr_en && !full;
  assign wr_take  = wr_acc && rst_n && !clear;
  assign rd_done  = rd_valid && rd_ready;
  assign out_load = !rd_valid || rd_ready;
  assign q_move   = q_vld && out_load;
  // mem_cnt counts words still in the array, not yet fetched into the prefetch register
  assign rd_issue = (mem_cnt != '0) && (!q_vld || q_move);

  always_comb begin
    mem_cnt_nxt = mem_cnt;
    if (wr_acc && !rd_issue) begin
      mem_cnt_nxt = mem_cnt + CW'(1);
    end else if (!wr_acc && rd_issue) begin
      mem_cnt_nxt = mem_cnt - CW'(1);
    end
  end

  always_comb begin
    fill_nxt = fill_level;
    if (wr_acc && !rd_done) begin
      fill_nxt = fill_level + CW'(1);
    end else if (!wr_acc && rd_done) begin
      fill_nxt = fill_level - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_take) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // The array's read register only advances when a fetch is issued, so it holds while the prefetch stage stalls
  always_ff @(posedge clk) begin
    if (rd_issue) begin
      mem_q <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      mem_cnt       <= '0;
      q_vld         <= 1'b0;
      rd_valid      <= 1'b0;
      rd_data       <= '0;
      fill_level    <= '0;
      threshold_irq <= 1'b0;
      overflow      <= 1'b0;
      drop_count    <= '0;
    end else begin
      threshold_irq <= (threshold != '0) && (fill_level >= threshold);
      if (clear) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        mem_cnt    <= '0;
        q_vld      <= 1'b0;
        rd_valid   <= 1'b0;
        fill_level <= '0;
        overflow   <= 1'b0;
        drop_count <= '0;
      end else begin
        if (wr_acc) begin
          wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
        end
        if (rd_issue) begin
          rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
        end
        mem_cnt    <= mem_cnt_nxt;
        fill_level <= fill_nxt;

        if (rd_issue) begin
          q_vld <= 1'b1;
        end else if (q_move) begin
          q_vld <= 1'b0;
        end

        if (out_load) begin
          rd_valid <= q_vld;
          if (q_vld) begin
            rd_data <= mem_q;
          end
        end

        if (wr_en && full) begin
          overflow <= 1'b1;
          if (drop_count != 16'hFFFF) begin
            drop_count <= drop_count + 16'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bram_ring_buffer.sv
// Bench for bram_ring_buffer: directed scenarios plus random traffic against a queue-based reference model.
module tb_bram_ring_buffer;

  localparam int DW    = 32;
  localparam int AW    = 14;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic [AW:0]   fill_level;
  logic [AW:0]   threshold;
  logic          threshold_irq;
  logic          overflow;
  logic [15:0]   drop_count;

  bram_ring_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear         (clear),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .rd_data       (rd_data),
    .fill_level    (fill_level),
    .threshold     (threshold),
    .threshold_irq (threshold_irq),
    .overflow      (overflow),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: each stored word remembers the edge it was written at;
  // the head of the queue is visible two edges after its write.
  typedef struct {
    logic [DW-1:0] d;
    int            e;
  } ent_t;

  ent_t mq[$];
  int   cyc     = 0;
  int   m_drops = 0;
  bit   m_ovf   = 1'b0;
  bit   m_irq   = 1'b0;

  function automatic bit head_visible();
    return (mq.size() > 0) && (mq[0].e + 2 <= cyc);
  endfunction

  task automatic step(input bit we, input logic [DW-1:0] wd, input bit rr, input bit clr, input bit rst);
    bit vis;
    bit rd_done;
    bit wr_acc;
    int lvl;
    wr_en    = we;
    wr_data  = wd;
    rd_ready = rr;
    clear    = clr;
    rst_n    = !rst;
    lvl      = mq.size();
    vis      = head_visible();
    rd_done  = vis && rr;
    wr_acc   = we && (lvl < DEPTH);
    @(posedge clk);
    cyc++;
    if (rst) begin
      mq.delete();
      m_ovf   = 1'b0;
      m_drops = 0;
      m_irq   = 1'b0;
    end else begin
      m_irq = (threshold != 0) && (lvl >= int'(threshold));
      if (clr) begin
        mq.delete();
        m_ovf   = 1'b0;
        m_drops = 0;
      end else begin
        if (rd_done) void'(mq.pop_front());
        if (wr_acc) mq.push_back('{d: wd, e: cyc});
        if (we && !wr_acc) begin
          m_ovf = 1'b1;
          if (m_drops < 65535) m_drops++;
        end
      end
    end
    #1;
    vis = head_visible();
    check("rd_valid", rd_valid, vis);
    if (vis) check("rd_data", rd_data, mq[0].d);
    check("fill_level", fill_level, mq.size());
    check("overflow", overflow, m_ovf);
    check("drop_count", drop_count, m_drops);
    check("threshold_irq", threshold_irq, m_irq);
  endtask

  task automatic idle(input bit rr);
    step(1'b0, '0, rr, 1'b0, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] pat;
    rst_n     = 1'b0;
    clear     = 1'b0;
    wr_en     = 1'b0;
    wr_data   = '0;
    rd_ready  = 1'b0;
    threshold = '0;

    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h1234_5678, 1'b1, 1'b1, 1'b1);
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_fill", fill_level, 0);

    // single word first-word-fall-through and hold
    idle(1'b0);
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    check("fwft_k", rd_valid, 1'b0);
    idle(1'b0);
    check("fwft_k1", rd_valid, 1'b0);
    idle(1'b0);
    check("fwft_k2_vld", rd_valid, 1'b1);
    check("fwft_k2_dat", rd_data, 32'hDEAD_BEEF);
    check("fwft_fill", fill_level, 1);
    repeat (10) idle(1'b0);
    check("fwft_hold", rd_data, 32'hDEAD_BEEF);
    repeat (3) idle(1'b1);
    check("fwft_drained", fill_level, 0);

    // fill to capacity, overflow by 3, then full read+write collision, then drain
    for (int i = 0; i < DEPTH + 3; i++) step(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
    check("full_fill", fill_level, DEPTH);
    check("full_ovf", overflow, 1'b1);
    check("full_drops", drop_count, 3);
    check("full_head", rd_data, 32'h0);
    step(1'b1, 32'h0BAD_0BAD, 1'b1, 1'b0, 1'b0);
    check("coll_fill", fill_level, DEPTH - 1);
    check("coll_drops", drop_count, 4);
    check("coll_next", rd_data, 32'h1);
    repeat (DEPTH + 2) idle(1'b1);
    check("drain_empty", fill_level, 0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("clear_ovf", overflow, 1'b0);

    // watermark interrupt
    threshold = 8;
    for (int i = 0; i < 8; i++) step(1'b1, DW'(100 + i), 1'b0, 1'b0, 1'b0);
    check("irq_lvl8", fill_level, 8);
    check("irq_lag", threshold_irq, 1'b0);
    idle(1'b0);
    check("irq_rise", threshold_irq, 1'b1);
    idle(1'b1);
    idle(1'b0);
    check("irq_fall", threshold_irq, 1'b0);
    threshold = 0;
    for (int i = 0; i < 30; i++) step(1'b1, DW'(200 + i), 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    check("irq_disabled", threshold_irq, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // address wrap
    pat = 32'h1000_0000;
    for (int i = 0; i < 12000; i++) begin
      step(1'b1, pat, 1'b0, 1'b0, 1'b0);
      pat++;
    end
    repeat (12000) idle(1'b1);
    for (int i = 0; i < 8000; i++) begin
      step(1'b1, pat, 1'b1, 1'b0, 1'b0);
      pat++;
    end
    repeat (4) idle(1'b1);
    check("wrap_empty", fill_level, 0);

    // flush with fill_level=100 and a concurrent write, via clear then via reset
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 100; i++) step(1'b1, DW'(300 + i), 1'b0, 1'b0, 1'b0);
      check("flush_pre", fill_level, 100);
      step(1'b1, 32'hAAAA_5555, 1'b1, k == 0, k == 1);
      check("flush_fill", fill_level, 0);
      check("flush_vld", rd_valid, 1'b0);
      check("flush_ovf", overflow, 1'b0);
      check("flush_drops", drop_count, 0);
      step(1'b1, 32'h00C0_FFEE + DW'(k), 1'b0, 1'b0, 1'b0);
      idle(1'b0);
      idle(1'b0);
      check("flush_first", rd_data, 32'h00C0_FFEE + DW'(k));
      idle(1'b1);
    end

    // random traffic with occasional clear/reset and varying watermark
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 199) == 0) threshold = (AW + 1)'($urandom_range(0, 24));
      step($urandom_range(0, 99) < 55, $urandom, $urandom_range(0, 99) < 50,
           $urandom_range(0, 599) == 0, $urandom_range(0, 999) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
